// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared types and constants for the iterative mul/div unit
// Revision   : 1.0
// ============================================================================
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mds_state_t;

  localparam int MDS_WIDTH   = 32;
  // Accepting edge to Done cycle, counted as in the core's cycle numbering
  localparam int MDS_LATENCY = MDS_WIDTH + 3;

  function automatic logic op_is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// muldiv_step : one shift-add multiply or restoring-divide iteration (comb.)
// Revision    : 1.0
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_pr;
  logic [WIDTH+1:0] w_trial;
  logic             w_fits;
  logic             w_unused_trial_msb;

  // Multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0]
  assign w_addend = i_acc_lo[0] ? i_operand : '0;
  assign w_sum    = {1'b0, i_acc_hi} + {1'b0, w_addend};

  // Divide: partial remainder is WIDTH+1 bits once the next dividend bit enters
  assign w_pr    = {i_acc_hi, i_acc_lo[WIDTH-1]};
  assign w_trial = {1'b0, w_pr} - {2'b00, i_operand};
  assign w_fits  = ~w_trial[WIDTH+1];
  // A fitting trial is below the divisor, so its bit WIDTH is always zero
  assign w_unused_trial_msb = w_trial[WIDTH];

  always_comb begin
    o_acc_hi = w_sum[WIDTH:1];
    o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
    if (i_is_div) begin
      o_acc_hi = w_fits ? w_trial[WIDTH-1:0] : w_pr[WIDTH-1:0];
      o_acc_lo = {i_acc_lo[WIDTH-2:0], w_fits};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : HI/LO registers plus FSM driving an iterative mul/div
// Revision         : 1.0
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MDS_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  op_t              Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       HiLoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mds_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             w_is_div;
  logic             w_is_signed;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_is_div    = op_is_div(op_q);
  assign w_is_signed = op_is_signed(op_q);
  assign w_neg_a     = w_is_signed & acc_lo_q[WIDTH-1];
  assign w_neg_b     = w_is_signed & opnd_q[WIDTH-1];

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_is_div  (w_is_div),
    .i_acc_hi  (acc_hi_q),
    .i_acc_lo  (acc_lo_q),
    .i_operand (opnd_q),
    .o_acc_hi  (w_step_hi),
    .o_acc_lo  (w_step_lo)
  );

  // Sign flags are zero for unsigned ops, so the fix-up needs no op check
  assign w_prod     = {acc_hi_q, acc_lo_q};
  assign w_prod_fix = (sign_a_q ^ sign_b_q) ? -w_prod : w_prod;
  assign w_quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
  assign w_rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (HiLoWrite[1]) hi_d = WrData;
        if (HiLoWrite[0]) lo_d = WrData;
        if (Start) begin
          state_d    = S_PREP;
          op_d       = Op;
          acc_lo_d   = A;
          opnd_d     = B;
          div_zero_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        sign_a_d = w_neg_a;
        sign_b_d = w_neg_b;
        acc_lo_d = w_neg_a ? -acc_lo_q : acc_lo_q;
        opnd_d   = w_neg_b ? -opnd_q : opnd_q;
        acc_hi_d = '0;
        cnt_d    = '0;
        if (w_is_div && (opnd_q == '0)) begin
          div_zero_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = w_step_hi;
        acc_lo_d = w_step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (w_is_div) begin
          hi_d = w_rem_fix;
          lo_d = w_quo_fix;
        end else begin
          hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
          lo_d = w_prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign Busy    = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign Done    = (state_q == S_DONE);
  assign DivZero = Done & div_zero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : directed vectors for the iterative mul/div sequencer
// Revision            : 1.0
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         Clk       = 1'b0;
  logic         Reset     = 1'b0;
  logic         Start     = 1'b0;
  op_t          Op        = OP_MULT;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic [1:0]   HiLoWrite = 2'b00;
  logic [W-1:0] WrData    = '0;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  muldiv_sequencer #(
    .WIDTH (W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HiLoWrite (HiLoWrite),
    .WrData    (WrData),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start is accepted at the next edge; inputs are then scrambled to prove latching
  task automatic accept(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    Op    = OP_DIVU;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Edges after the accepting edge until Done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;
  int extra_done;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_dz",   64'(DivZero), 64'd0);
    check("rst_hi",   64'(Hi), 64'd0);
    check("rst_lo",   64'(Lo), 64'd0);
    Reset = 1'b1;
    tick();

    // 1. MULT 7 * -3; Done after the accepting edge plus WIDTH+2 edges
    accept(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    check("t1_busy", 64'(Busy), 64'd1);
    wait_done(n);
    check("t1_lat", 64'(n), 64'(MDS_LATENCY - 1));
    check("t1_hi",  64'(Hi), 64'hFFFF_FFFF);
    check("t1_lo",  64'(Lo), 64'hFFFF_FFEB);
    check("t1_dz",  64'(DivZero), 64'd0);
    check("t1_busy_at_done", 64'(Busy), 64'd0);
    tick();
    check("t1_done_pulse", 64'(Done), 64'd0);

    // 2. MULTU max*max, with an ignored Start while busy
    accept(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) tick();
    Start = 1'b1; Op = OP_MULT; A = 32'd2; B = 32'd3;
    tick();
    Start = 1'b0;
    wait_done(n);
    check("t2_lat", 64'(n + 6), 64'(MDS_LATENCY - 1));
    check("t2_hi",  64'(Hi), 64'hFFFF_FFFE);
    check("t2_lo",  64'(Lo), 64'h0000_0001);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done === 1'b1) extra_done++;
    end
    check("t2_no_second_done", 64'(extra_done), 64'd0);
    check("t2_hi_kept", 64'(Hi), 64'hFFFF_FFFE);

    // 3. DIV -7 / 2
    accept(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("t3_lat", 64'(n), 64'(MDS_LATENCY - 1));
    check("t3_lo",  64'(Lo), 64'hFFFF_FFFD);
    check("t3_hi",  64'(Hi), 64'hFFFF_FFFF);

    // 4. DIV wrap case, then DIVU issued straight from DONE
    tick();
    accept(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("t4a_lo", 64'(Lo), 64'h8000_0000);
    check("t4a_hi", 64'(Hi), 64'h0000_0000);
    check("t4a_dz", 64'(DivZero), 64'd0);
    accept(OP_DIVU, 32'd100, 32'd7);
    check("t4b_busy", 64'(Busy), 64'd1);
    wait_done(n);
    check("t4b_lat", 64'(n), 64'(MDS_LATENCY - 1));
    check("t4b_lo",  64'(Lo), 64'd14);
    check("t4b_hi",  64'(Hi), 64'd2);
    tick();

    // 5. mthi then DIVU by zero
    HiLoWrite = 2'b10; WrData = 32'h0000_1234;
    tick();
    HiLoWrite = 2'b00; WrData = 32'hDEAD_BEEF;
    check("t5_mthi", 64'(Hi), 64'h1234);
    accept(OP_DIVU, 32'd5, 32'd0);
    wait_done(n);
    check("t5_lat", 64'(n), 64'd1);
    check("t5_dz",  64'(DivZero), 64'd1);
    check("t5_hi",  64'(Hi), 64'h1234);
    check("t5_lo",  64'(Lo), 64'd14);
    tick();
    check("t5_dz_clear", 64'(DivZero), 64'd0);

    // 6. Reset mid-MULT, then a fresh MULTU
    accept(OP_MULT, 32'd9, 32'd9);
    repeat (9) tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check("t6_busy", 64'(Busy), 64'd0);
    check("t6_done", 64'(Done), 64'd0);
    check("t6_hi",   64'(Hi), 64'd0);
    check("t6_lo",   64'(Lo), 64'd0);
    accept(OP_MULTU, 32'd3, 32'd5);
    wait_done(n);
    check("t6_lat", 64'(n), 64'(MDS_LATENCY - 1));
    check("t6_hi2", 64'(Hi), 64'd0);
    check("t6_lo2", 64'(Lo), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
